// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and baud divisor helper for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int DATA_BITS   = 8;
    localparam int IDX_W       = $clog2(DATA_BITS);
    localparam int SYNC_STAGES = 2;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int rate;
        rate = baud * oversample;
        return (clk_freq + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead FIFO for received bytes; full push without pop drops and sets sticky overrun
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             overrun_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overrun_q, overrun_d;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i && !do_push) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            end
        end
    end

    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o   = empty;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - oversampling 8N1 UART receiver with show-ahead byte FIFO and slow-domain read handshake
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH      = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    input  logic                 RX_READ,
    output logic [DATA_BITS-1:0] UART_RXD,
    output logic                 RX_EFF,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
);

    localparam int DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int SAMP_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] rx_sync_q;
    logic                   rx_prev_q;
    logic [SYNC_STAGES-1:0] rd_sync_q;
    logic                   rd_prev_q;
    logic                   rx_s;
    logic                   rx_fall;
    logic                   rd_rise;

    rx_state_e              state_q, state_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic [SAMP_W-1:0]      samp_cnt_q, samp_cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   tick;
    logic                   push;
    logic                   fifo_empty;

    // Idle-high line syncs to 1 so reset never looks like a start edge.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_sync_q <= '1;
            rx_prev_q <= 1'b1;
            rd_sync_q <= '0;
            rd_prev_q <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], UART_RX};
            rx_prev_q <= rx_sync_q[SYNC_STAGES-1];
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], RX_READ};
            rd_prev_q <= rd_sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s    = rx_sync_q[SYNC_STAGES-1];
    assign rx_fall = rx_prev_q & ~rx_s;
    assign rd_rise = rd_sync_q[SYNC_STAGES-1] & ~rd_prev_q;
    assign tick    = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        samp_cnt_d  = samp_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        case (state_q)
            IDLE: begin
                div_cnt_d  = '0;
                samp_cnt_d = '0;
                if (rx_fall) begin
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_MID) begin
                        samp_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d = '0;
                        if (^{rx_s, shift_q}) begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        // Returning to IDLE on a low stop bit is safe: rearm needs a fresh 1->0 edge.
                        state_d     = IDLE;
                        push        = rx_s;
                        frame_err_d = ~rx_s;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            samp_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk         (sysclk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (rd_rise),
        .rdata_o     (UART_RXD),
        .empty_o     (fifo_empty),
        .overrun_o   (OVERRUN)
    );

    assign RX_EFF    = ~fifo_empty;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - randomized self-checking bench for uart_rx_buffered against a byte-queue model
module tb_uart_rx_buffered;

    localparam int CLK_FREQ = 6400000;
    localparam int BAUD     = 100000;
    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;

    logic       sysclk  = 1'b0;
    logic       reset   = 1'b0;
    logic       UART_RX = 1'b1;
    logic       RX_READ = 1'b0;
    logic [7:0] UART_RXD;
    logic       RX_EFF;
    logic       FRAME_ERR;
    logic       OVERRUN;

    int       n_checks = 0;
    int       n_pass   = 0;
    int       fe_cnt   = 0;
    int       fe_exp   = 0;
    int       fe0      = 0;
    bit [7:0] exp_q[$];
    bit       ovr_exp  = 1'b0;

    always #5 sysclk = ~sysclk;

    uart_rx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DEPTH      (DEPTH)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .RX_READ   (RX_READ),
        .UART_RXD  (UART_RXD),
        .RX_EFF    (RX_EFF),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN)
    );

    always @(negedge sysclk) begin
        if (FRAME_ERR === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input bit [7:0] b, input bit stop_ok);
        UART_RX = 1'b0;
        cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            cyc(BIT_CYC);
        end
        UART_RX = stop_ok;
        cyc(BIT_CYC);
        UART_RX = 1'b1;
        cyc(16);
    endtask

    task automatic model_frame(input bit [7:0] b, input bit stop_ok);
        if (!stop_ok) fe_exp++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else ovr_exp = 1'b1;
    endtask

    task automatic send(input bit [7:0] b, input bit stop_ok);
        send_frame(b, stop_ok);
        model_frame(b, stop_ok);
    endtask

    task automatic read_one(input int hold);
        bit [7:0] head;
        if (exp_q.size() > 0) begin
            check("rx_eff_before_read", RX_EFF, 1);
            check("rxd_head", UART_RXD, exp_q[0]);
            head = exp_q.pop_front();
        end else begin
            check("rx_eff_empty_read", RX_EFF, 0);
        end
        RX_READ = 1'b1;
        cyc(hold);
        RX_READ = 1'b0;
        cyc(6);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        exp_q.delete();
        ovr_exp = 1'b0;
        cyc(4);
    endtask

    initial begin
        bit [7:0] b;
        bit       ok;

        cyc(3);
        check("reset_rxd", UART_RXD, 8'h00);
        check("reset_rx_eff", RX_EFF, 0);
        check("reset_frame_err", FRAME_ERR, 0);
        check("reset_overrun", OVERRUN, 0);
        reset = 1'b1;
        cyc(5);

        fe0 = fe_cnt;
        send(8'h55, 1'b1);
        check("byte55_rx_eff", RX_EFF, 1);
        check("byte55_rxd", UART_RXD, 8'h55);
        check("byte55_no_frame_err", fe_cnt - fe0, 0);
        read_one(16);
        check("byte55_drained", RX_EFF, 0);

        fe0 = fe_cnt;
        UART_RX = 1'b0;
        cyc(4);
        UART_RX = 1'b1;
        cyc(3 * BIT_CYC);
        check("glitch_no_byte", RX_EFF, 0);
        check("glitch_no_err", fe_cnt - fe0, 0);

        fe0 = fe_cnt;
        send(8'h3C, 1'b0);
        check("badstop_one_pulse", fe_cnt - fe0, 1);
        check("badstop_discarded", RX_EFF, 0);
        send(8'hA5, 1'b1);
        read_one(16);
        check("after_badstop_err_cnt", fe_cnt - fe0, 1);

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        check("overrun_set", OVERRUN, ovr_exp);
        check("overrun_head", UART_RXD, 8'h01);
        for (int i = 0; i < 4; i++) read_one(512);
        check("overrun_drained", RX_EFF, 0);
        check("overrun_sticky", OVERRUN, 1);

        do_reset();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        // The read edge reaches the FIFO in the cycle the 5th stop bit is sampled.
        fork
            send_frame(8'h05, 1'b1);
            begin
                cyc(BIT_CYC * 19 / 2);
                RX_READ = 1'b1;
                cyc(16);
                RX_READ = 1'b0;
            end
        join
        b = exp_q.pop_front();
        model_frame(8'h05, 1'b1);
        check("coincide_no_overrun", OVERRUN, ovr_exp);
        check("coincide_head", UART_RXD, 8'h02);
        for (int i = 0; i < 4; i++) read_one(16);
        check("coincide_drained", RX_EFF, 0);

        do_reset();
        fe_exp = 0;
        fe0 = fe_cnt;
        for (int i = 0; i < 10; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send(b, ok);
            if ($urandom_range(0, 1) == 1) read_one(8);
        end
        while (exp_q.size() > 0) read_one(8);
        check("rand_frame_errs", fe_cnt - fe0, fe_exp);
        check("rand_overrun", OVERRUN, ovr_exp);
        check("rand_drained", RX_EFF, 0);

        send(8'h5A, 1'b1);
        check("pre_reset_rx_eff", RX_EFF, 1);
        fe0 = fe_cnt;
        UART_RX = 1'b0;
        cyc(BIT_CYC);
        UART_RX = 1'b1;
        cyc(3 * BIT_CYC);
        reset = 1'b0;
        cyc(2);
        check("middata_rst_rxd", UART_RXD, 8'h00);
        check("middata_rst_rx_eff", RX_EFF, 0);
        check("middata_rst_frame_err", FRAME_ERR, 0);
        check("middata_rst_overrun", OVERRUN, 0);
        reset = 1'b1;
        exp_q.delete();
        ovr_exp = 1'b0;
        cyc(6 * BIT_CYC);
        send(8'h81, 1'b1);
        read_one(16);
        check("after_rst_drained", RX_EFF, 0);
        check("after_rst_no_err", fe_cnt - fe0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
